// File: rtl/fatori_fi_ctrl.sv
// rtl/fatori_fi_ctrl.sv - fault-injection campaign initiator sweeping an ID range on the fi_port bus
// Optional gap jitter from a 16-bit Galois LFSR when FATORI_FI_RAND_EN is defined.
module fatori_fi_ctrl #(
    parameter int              ID_W    = 8,
    parameter logic [ID_W-1:0] IDLE_ID = '1,
    parameter int              GAP_W   = 16,
    parameter int              CNT_W   = 16,
    parameter int              OBS_CYC = 64,
    parameter int              JIT_W   = 4
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [ID_W-1:0]  first_id_i,
    input  logic [ID_W-1:0]  last_id_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             new_min_err_i,
    input  logic             new_maj_err_i,
    input  logic             scrub_i,
    output logic [ID_W-1:0]  fi_port_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] inj_cnt_o,
    output logic [CNT_W-1:0] min_cnt_o,
    output logic [CNT_W-1:0] maj_cnt_o,
    output logic [CNT_W-1:0] scrub_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int WIN_W = $clog2(OBS_CYC + 1);
    localparam int SUM_W = GAP_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_INJECT,
        S_OBSERVE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    cur_id_q;
    logic [ID_W-1:0]    last_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [ID_W-1:0]    fi_port_q;
    logic [CNT_W-1:0]   inj_q, min_q, maj_q, scrub_q, miss_q;

    logic               clr;
    logic               inj_fire;
    logic               err_any;
    logic               obs_live;
    logic               obs_min, obs_maj, obs_miss;
    logic               scrub_hit;
    logic               win_last;
    logic [GAP_W-1:0]   gap_base;
    logic [SUM_W-1:0]   gap_sum;
    logic [GAP_W-1:0]   gap_load;
    logic [JIT_W-1:0]   jit;

`ifdef FATORI_FI_RAND_EN
    logic [15:0] lfsr_q;

    // Right-shifting Galois form; mask 16'hB400 realises taps 16,14,13,11.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign jit = lfsr_q[JIT_W-1:0];
`else
    assign jit = '0;
`endif

    // The first GAP of a campaign is entered on the start edge, before gap_q holds gap_i.
    assign gap_base = (state_q == S_IDLE) ? gap_i : gap_q;
    assign gap_sum  = {1'b0, gap_base} + SUM_W'(jit);
    assign gap_load = gap_sum[GAP_W] ? '1 : gap_sum[GAP_W-1:0];

    assign err_any   = new_min_err_i | new_maj_err_i;
    assign win_last  = (win_cnt_q == WIN_W'(1));
    assign clr       = (state_q == S_IDLE) && start_i;
    assign inj_fire  = (state_q == S_INJECT) && (cur_id_q != IDLE_ID) && !abort_i;
    assign obs_live  = (state_q == S_OBSERVE) && !abort_i;
    assign obs_min   = obs_live && new_min_err_i;
    assign obs_maj   = obs_live && new_maj_err_i;
    assign obs_miss  = obs_live && !err_any && win_last;
    assign scrub_hit = (state_q != S_IDLE) && scrub_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (last_id_i < first_id_i) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_INJECT;
                end
            end
            S_INJECT: begin
                state_d = (cur_id_q == IDLE_ID) ? S_NEXT : S_OBSERVE;
            end
            S_OBSERVE: begin
                if (err_any || win_last) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = (cur_id_q == last_q) ? S_DONE : S_GAP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // DONE already terminates, so an abort there must not stretch the done pulse.
        if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= S_IDLE;
            fi_port_q <= IDLE_ID;
            cur_id_q  <= '0;
            last_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fi_port_q <= inj_fire ? cur_id_q : IDLE_ID;
            if (clr) begin
                cur_id_q <= first_id_i;
                last_q   <= last_id_i;
                gap_q    <= gap_i;
            end else if ((state_q == S_NEXT) && (state_d == S_GAP)) begin
                cur_id_q <= cur_id_q + ID_W'(1);
            end
            if ((state_d == S_GAP) && (state_q != S_GAP)) begin
                gap_cnt_q <= gap_load;
            end else if ((state_q == S_GAP) && (gap_cnt_q != '0)) begin
                gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
            if (state_q == S_INJECT) begin
                win_cnt_q <= WIN_W'(OBS_CYC);
            end else if ((state_q == S_OBSERVE) && (win_cnt_q != '0)) begin
                win_cnt_q <= win_cnt_q - WIN_W'(1);
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            inj_q   <= '0;
            min_q   <= '0;
            maj_q   <= '0;
            scrub_q <= '0;
            miss_q  <= '0;
        end else if (clr) begin
            inj_q   <= '0;
            min_q   <= '0;
            maj_q   <= '0;
            scrub_q <= '0;
            miss_q  <= '0;
        end else begin
            inj_q   <= sat_inc(inj_q, inj_fire);
            min_q   <= sat_inc(min_q, obs_min);
            maj_q   <= sat_inc(maj_q, obs_maj);
            scrub_q <= sat_inc(scrub_q, scrub_hit);
            miss_q  <= sat_inc(miss_q, obs_miss);
        end
    end

    assign fi_port_o   = fi_port_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign inj_cnt_o   = inj_q;
    assign min_cnt_o   = min_q;
    assign maj_cnt_o   = maj_q;
    assign scrub_cnt_o = scrub_q;
    assign miss_cnt_o  = miss_q;

endmodule

// File: tb/tb_fatori_fi_ctrl.sv
// tb/tb_fatori_fi_ctrl.sv - randomized self-checking bench for fatori_fi_ctrl
// Each campaign is planned as a cycle timeline up front; DUT outputs are compared per cycle.
module tb_fatori_fi_ctrl;

    localparam int OBS  = 64;
    localparam int IDLE = 255;
    localparam int MAXC = 2048;
    localparam int TAIL = 3;

    logic        clk = 1'b0;
    logic        arst;
    logic        start, abort_in, nmin, nmaj, scrub;
    logic [7:0]  first_id, last_id;
    logic [15:0] gap;
    logic [7:0]  fi_port;
    logic        busy, done;
    logic [15:0] inj_cnt, min_cnt, maj_cnt, scrub_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_fi   [0:MAXC-1];
    bit         exp_busy [0:MAXC-1];
    bit         exp_done [0:MAXC-1];
    bit         in_min   [0:MAXC-1];
    bit         in_maj   [0:MAXC-1];
    bit         in_scrub [0:MAXC-1];
    bit         in_abort [0:MAXC-1];
    bit         in_start [0:MAXC-1];
    int         e_inj, e_min, e_maj, e_scrub, e_miss;

    fatori_fi_ctrl dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .start_i      (start),
        .abort_i      (abort_in),
        .first_id_i   (first_id),
        .last_id_i    (last_id),
        .gap_i        (gap),
        .new_min_err_i(nmin),
        .new_maj_err_i(nmaj),
        .scrub_i      (scrub),
        .fi_port_o    (fi_port),
        .busy_o       (busy),
        .done_o       (done),
        .inj_cnt_o    (inj_cnt),
        .min_cnt_o    (min_cnt),
        .maj_cnt_o    (maj_cnt),
        .scrub_cnt_o  (scrub_cnt),
        .miss_cnt_o   (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string tag, input int i, input int mn, input int mj,
                                input int sc, input int ms);
        chk({tag, " inj"},   32'(inj_cnt),   i);
        chk({tag, " min"},   32'(min_cnt),   mn);
        chk({tag, " maj"},   32'(maj_cnt),   mj);
        chk({tag, " scrub"}, 32'(scrub_cnt), sc);
        chk({tag, " miss"},  32'(miss_cnt),  ms);
    endtask

    // resp: 0 random, 1 minor 3 cycles after pulse, 2 no response, 3 minor+major 3 cycles after
    // abort_sel: -1 none, -2 random cycle, -3 first GAP cycle of the second ID, >=0 that cycle
    // scrub_mode: 0 random, 1 pulses in cycles 0 and 1, 2 none
    task automatic run_campaign(input int first, input int last, input int g, input int resp,
                                input int abort_sel, input bit noise, input int scrub_mode,
                                input string tag);
        int s, id, p, d, kind, nxt, done_idx, a, lim;
        int pulse_t[$];
        int pulse_id[$];
        int min_t[$];
        int maj_t[$];
        int miss_t[$];
        int gap_s[$];
        for (int t = 0; t < MAXC; t++) begin
            exp_fi[t] = 8'(IDLE); exp_busy[t] = 0; exp_done[t] = 0;
            in_min[t] = 0; in_maj[t] = 0; in_scrub[t] = 0; in_abort[t] = 0; in_start[t] = 0;
        end
        done_idx = 0;
        if (last >= first) begin
            s  = 0;
            id = first;
            while (1'b1) begin
                gap_s.push_back(s);
                if (noise) begin
                    for (int t = s; t <= s + g + 1; t++) begin
                        in_min[t] = ($urandom_range(0, 2) == 0);
                        in_maj[t] = ($urandom_range(0, 2) == 0);
                    end
                end
                if (id == IDLE) begin
                    nxt = s + g + 2;
                end else begin
                    p = s + g + 2;
                    pulse_t.push_back(p);
                    pulse_id.push_back(id);
                    d = (resp == 0) ? int'($urandom_range(0, OBS + 8)) : (resp == 2) ? OBS : 3;
                    if (d < OBS) begin
                        kind = (resp == 0) ? int'($urandom_range(1, 3)) : (resp == 1) ? 1 : 3;
                        if (kind & 1) begin min_t.push_back(p + d); in_min[p + d] = 1; end
                        if (kind & 2) begin maj_t.push_back(p + d); in_maj[p + d] = 1; end
                        nxt = p + d + 1;
                    end else begin
                        miss_t.push_back(p + OBS - 1);
                        nxt = p + OBS;
                    end
                    if (noise) in_min[nxt] = ($urandom_range(0, 1) == 1);
                end
                if (id == last) begin
                    done_idx = nxt + 1;
                    break;
                end
                id++;
                s = nxt + 1;
            end
        end
        a = -1;
        if (abort_sel == -2 && done_idx > 0) a = int'($urandom_range(0, done_idx - 1));
        if (abort_sel == -3 && gap_s.size() > 1) a = gap_s[1];
        if (abort_sel >= 0 && abort_sel < done_idx) a = abort_sel;
        if (a >= 0) begin
            in_abort[a] = 1;
            done_idx = a + 1;
        end
        // An event counts only when its deciding cycle precedes the abort cycle.
        lim = (a >= 0) ? a : done_idx;
        e_inj = 0; e_min = 0; e_maj = 0; e_miss = 0; e_scrub = 0;
        foreach (pulse_t[i]) begin
            if (pulse_t[i] - 1 < lim) begin
                e_inj++;
                exp_fi[pulse_t[i]] = 8'(pulse_id[i]);
            end
        end
        foreach (min_t[i])  if (min_t[i]  < lim) e_min++;
        foreach (maj_t[i])  if (maj_t[i]  < lim) e_maj++;
        foreach (miss_t[i]) if (miss_t[i] < lim) e_miss++;
        for (int t = done_idx; t <= done_idx + TAIL; t++) begin
            in_min[t] = noise && ($urandom_range(0, 1) == 1);
            in_maj[t] = noise && ($urandom_range(0, 1) == 1);
        end
        for (int t = 0; t <= done_idx + TAIL; t++) begin
            in_scrub[t] = (scrub_mode == 0) ? ($urandom_range(0, 2) == 0) :
                          (scrub_mode == 1) ? (t < 2) : 1'b0;
            if (in_scrub[t] && t <= done_idx) e_scrub++;
            in_start[t] = (t < done_idx) && ($urandom_range(0, 7) == 0);
            exp_busy[t] = (t <= done_idx);
        end
        exp_done[done_idx] = 1;

        first_id = 8'(first); last_id = 8'(last); gap = 16'(g);
        start = 1; abort_in = 0; nmin = 0; nmaj = 0; scrub = 0;
        for (int t = 0; t <= done_idx + TAIL; t++) begin
            @(negedge clk);
            chk($sformatf("%s fi_port t=%0d", tag, t), 32'(fi_port), 32'(exp_fi[t]));
            chk($sformatf("%s busy t=%0d", tag, t), 32'(busy), 32'(exp_busy[t]));
            chk($sformatf("%s done t=%0d", tag, t), 32'(done), 32'(exp_done[t]));
            if (t > done_idx) chk_counters(tag, e_inj, e_min, e_maj, e_scrub, e_miss);
            start    = in_start[t];
            abort_in = in_abort[t];
            nmin     = in_min[t];
            nmaj     = in_maj[t];
            scrub    = in_scrub[t];
            first_id = 8'($urandom);
            last_id  = 8'($urandom);
            gap      = 16'($urandom);
        end
        start = 0; abort_in = 0; nmin = 0; nmaj = 0; scrub = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int f, l, g, asel;
        arst = 1; start = 0; abort_in = 0; nmin = 0; nmaj = 0; scrub = 0;
        first_id = 0; last_id = 0; gap = 0;
        repeat (3) @(negedge clk);
        chk("reset fi_port", 32'(fi_port), 255);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk_counters("reset", 0, 0, 0, 0, 0);
        arst = 0;
        @(negedge clk);

        run_campaign(3, 5, 2, 1, -1, 0, 2, "sweep3to5");
        chk_counters("sweep3to5 lit", 3, 3, 0, 0, 0);

        run_campaign(7, 7, 1, 2, -1, 0, 2, "single_miss");
        chk_counters("single_miss lit", 1, 0, 0, 0, 1);

        run_campaign(20, 20, 2, 3, -1, 0, 1, "both_err");
        chk_counters("both_err lit", 1, 1, 1, 2, 0);

        run_campaign(0, 9, 1, 1, -3, 0, 2, "abort_gap");
        chk_counters("abort_gap lit", 1, 1, 0, 0, 0);
        chk("abort_gap fi idle", 32'(fi_port), 255);

        run_campaign(5, 3, 2, 0, -1, 1, 0, "reversed");
        chk("reversed inj lit", 32'(inj_cnt), 0);

        run_campaign(254, 255, 0, 1, -1, 0, 2, "top_ids");
        chk_counters("top_ids lit", 1, 1, 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(252, 255)) : int'($urandom_range(0, 200));
            l = f + int'($urandom_range(0, 3));
            if (l > 255) l = 255;
            if (f > 0 && $urandom_range(0, 7) == 0) l = f - 1;
            g = int'($urandom_range(0, 4));
            asel = ($urandom_range(0, 2) == 0) ? -2 : -1;
            run_campaign(f, l, g, 0, asel, 1, 0, $sformatf("rnd%0d", n));
        end

        first_id = 10; last_id = 12; gap = 3; start = 1;
        @(negedge clk);
        start = 0; scrub = 1;
        repeat (7) @(negedge clk);
        #2 arst = 1;
        #1;
        chk("midreset fi_port", 32'(fi_port), 255);
        chk("midreset busy", 32'(busy), 0);
        chk("midreset done", 32'(done), 0);
        chk_counters("midreset", 0, 0, 0, 0, 0);
        @(negedge clk);
        arst = 0; scrub = 0;
        @(negedge clk);
        run_campaign(1, 2, 0, 0, -1, 1, 0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
